window_fetch_unit: RTL and testbench
====================================

// Module: window_fetch_unit
// PURPOSE
// - Consumer of the serpentine walk: takes the centre read address and move direction from the walker.
// - Fetches the pixels from image SRAM and maintains the 3x3 Sobel window register.
// - A full 9-pixel load runs on load_initial; each move fetches only the new 3-pixel column or row.
// - The window is shifted atomically, so it stays stable until fetch_done.
// PARAMETERS
// - PIXEL_W     8    pixel width in bits
// - ADDR_W      8    SRAM address width; all address arithmetic is modulo 2**ADDR_W
// - TIMEOUT_CYC 255  read-response watchdog limit; used only with FETCH_TIMEOUT_EN
// PORTS
// - clk            in   1          rising-edge clock (the only clock)
// - n_reset        in   1          asynchronous active-low reset
// - load_initial   in   1          pulse: start a full 9-pixel load around center_addr
// - move_strobe    in   1          pulse: fetch for direction; center_addr is already the new centre
// - direction      in   2          00 none, 01 right (+1), 10 left (-1), 11 down (+stride)
// - center_addr    in   ADDR_W     address of the window centre pixel
// - row_stride     in   12         image line length in pixels; truncated to ADDR_W for arithmetic
// - mem_rd         out  1          read request; held until mem_rvalid
// - mem_addr       out  ADDR_W     read address; stable while mem_rd is high
// - mem_rdata      in   PIXEL_W    read data
// - mem_rvalid     in   1          read data valid; latency >=1 cycle; one read outstanding at most
// - window         out  9*PIXEL_W  w[r*3+c] at bits [(r*3+c)*PIXEL_W +: PIXEL_W]; r0 = top row, c0 = left column
// - window_valid   out  1          window holds a complete, coherent 3x3 neighbourhood
// - busy           out  1          fetch in progress
// - fetch_done     out  1          one-cycle pulse when the window has been updated
// - fetch_error    out  1          timeout flag (FETCH_TIMEOUT_EN only; tied 0 otherwise)
// BEHAVIOUR
// - Reset: all outputs 0, window all 0, FSM in IDLE, drop flag clear.
// - FSM states and transitions:
//   - IDLE: accept a command.
//   - REQ: mem_rd=1 and mem_addr=tgt[idx] until mem_rvalid.
//   - CAPTURE: store the pixel into stage[idx]; idx++; go back to REQ if pixels remain, else go to COMMIT.
//   - COMMIT: apply stage to the window; pulse fetch_done; set window_valid; return to IDLE.
// - Offsets use S = row_stride[ADDR_W-1:0] and C = center_addr.
//   - Initial load, order r0c0..r2c2: C-S-1, C-S, C-S+1, C-1, C, C+1, C+S-1, C+S, C+S+1.
//   - Right: new column 2 at C-S+1, C+1, C+S+1. Commit shifts columns left (c0<=c1, c1<=c2, c2<=stage).
//   - Left: new column 0 at C-S-1, C-1, C+S-1. Commit shifts columns right.
//   - Down: new row 2 at C+S-1, C+S, C+S+1. Commit shifts rows up.
//   - All sums wrap modulo 2**ADDR_W; no clamping.
// - Latency: move = 3*(L+1)+1 cycles; initial load = 9*(L+1)+1 cycles, where L is the memory latency.
//   - Example, L=1: move 7 cycles, initial load 19 cycles from strobe to fetch_done.
// - Command handling:
//   - move_strobe with direction 00: no reads; fetch_done pulses the next cycle; window unchanged.
//   - move_strobe while busy, or while window_valid=0: ignored.
//   - load_initial has priority over move_strobe in the same cycle.
// - load_initial mid-fetch: abort the current fetch, clear window_valid, restart the 9-pixel load.
//   - If a read is outstanding, set the drop flag; the next mem_rvalid is discarded, then the new sequence issues.
// - Inputs are sampled only on the accept cycle. center_addr and row_stride may change during a fetch.
// CONFIGURATION
// - FETCH_TIMEOUT_EN defined:
//   - A watchdog counts REQ cycles without mem_rvalid.
//   - At TIMEOUT_CYC: abort to IDLE, set fetch_error (sticky until the next load_initial), clear window_valid, no fetch_done.
// - FETCH_TIMEOUT_EN undefined: no counter; fetch_error = 0; the FSM waits indefinitely.
// STRUCTURE
// - Package sobel_win_pkg:
//   - dir_t enum: DIR_NONE, DIR_RIGHT, DIR_LEFT, DIR_DOWN = 2'b00..2'b11.
//   - wf_state_t enum: IDLE, REQ, CAPTURE, COMMIT.
//   - localparam NUM_INIT=9, NUM_MOVE=3.
// - Sub-module win_addr_gen: combinational; maps (C, S, mode, idx) to the target address. One instance.
// TESTING
// - Initial load: C=8'h22, S=16, L=1, memory returns addr as data. After 19 cycles: window = 11,12,13,21,22,23,31,32,33 (hex); window_valid=1.
// - Right: then C=8'h23, dir=01. Exactly 3 reads (14,24,34); window = 12,13,14,22,23,24,32,33,34; fetch_done one cycle.
// - Down then left: dir=11 with C=8'h33 reads 42,43,44; then dir=10 with C=8'h32 reads 21,31,41. Window rows/columns shift correctly.
// - Abort: load_initial during the second read with L=3. The stale mem_rvalid is dropped; 9 fresh reads follow; no fetch_done for the aborted move.
// - Wrap and edge cases: C=8'h00, S=16, load reads EF,F0,F1,FF,00,01,0F,10,11. move_strobe while busy: no effect. dir=00: fetch_done next cycle, no mem_rd.
// - FETCH_TIMEOUT_EN: hold mem_rvalid=0. After 255 cycles: fetch_error=1, busy=0, window_valid=0. load_initial clears fetch_error.

Source files
------------

// File: rtl/sobel_win_pkg.sv
// Shared types and constants for the Sobel 3x3 window fetch unit.
package sobel_win_pkg;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    CAPTURE,
    COMMIT
  } wf_state_t;

  localparam int NUM_INIT = 9;
  localparam int NUM_MOVE = 3;
  localparam int IDX_W    = 4;

  function automatic logic [IDX_W-1:0] last_index(input logic init);
    return init ? IDX_W'(NUM_INIT - 1) : IDX_W'(NUM_MOVE - 1);
  endfunction

endpackage

// File: rtl/window_fetch_unit_addr_gen.sv
// win_addr_gen: maps (centre, stride, fetch mode, pixel index) to the SRAM address.
// All arithmetic wraps modulo 2**ADDR_W.
module win_addr_gen
  import sobel_win_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] center,
  input  logic [ADDR_W-1:0] stride,
  input  logic              init,
  input  dir_t              dir,
  input  logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] addr
);

  logic [1:0]        row_sel;
  logic [1:0]        col_sel;
  logic [ADDR_W-1:0] row_off;
  logic [ADDR_W-1:0] col_off;

  always_comb begin
    row_sel = 2'd1;
    col_sel = 2'd1;
    if (init) begin
      case (idx)
        4'd0:    {row_sel, col_sel} = {2'd0, 2'd0};
        4'd1:    {row_sel, col_sel} = {2'd0, 2'd1};
        4'd2:    {row_sel, col_sel} = {2'd0, 2'd2};
        4'd3:    {row_sel, col_sel} = {2'd1, 2'd0};
        4'd4:    {row_sel, col_sel} = {2'd1, 2'd1};
        4'd5:    {row_sel, col_sel} = {2'd1, 2'd2};
        4'd6:    {row_sel, col_sel} = {2'd2, 2'd0};
        4'd7:    {row_sel, col_sel} = {2'd2, 2'd1};
        4'd8:    {row_sel, col_sel} = {2'd2, 2'd2};
        default: {row_sel, col_sel} = {2'd1, 2'd1};
      endcase
    end else begin
      // Moves fetch one edge of the window: idx walks down a column or across a row.
      case (dir)
        DIR_RIGHT: begin row_sel = idx[1:0]; col_sel = 2'd2;     end
        DIR_LEFT:  begin row_sel = idx[1:0]; col_sel = 2'd0;     end
        DIR_DOWN:  begin row_sel = 2'd2;     col_sel = idx[1:0]; end
        default:   begin row_sel = 2'd1;     col_sel = 2'd1;     end
      endcase
    end
  end

  always_comb begin
    case (row_sel)
      2'd0:    row_off = '0 - stride;
      2'd2:    row_off = stride;
      default: row_off = '0;
    endcase
    case (col_sel)
      2'd0:    col_off = '1;
      2'd2:    col_off = ADDR_W'(1);
      default: col_off = '0;
    endcase
    addr = center + row_off + col_off;
  end

endmodule

// File: rtl/window_fetch_unit.sv
// Fetches the 3x3 Sobel window from image SRAM: full load on load_initial, one edge per move.
// Optional read watchdog enabled by defining FETCH_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | window stable, waiting for load_initial or move_strobe
// REQ     | read request for pixel idx held until mem_rvalid (or stale response drained)
// CAPTURE | pixel stored in stage[idx]; last pixel also commits the window
// COMMIT  | window updated, fetch_done pulses
module window_fetch_unit
  import sobel_win_pkg::*;
#(
  parameter int PIXEL_W     = 8,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 load_initial,
  input  logic                 move_strobe,
  input  logic [1:0]           direction,
  input  logic [ADDR_W-1:0]    center_addr,
  input  logic [11:0]          row_stride,
  output logic                 mem_rd,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [PIXEL_W-1:0]   mem_rdata,
  input  logic                 mem_rvalid,
  output logic [9*PIXEL_W-1:0] window,
  output logic                 window_valid,
  output logic                 busy,
  output logic                 fetch_done,
  output logic                 fetch_error
);

  wf_state_t          state, state_nxt;
  logic [IDX_W-1:0]   idx;
  logic               init_q;
  dir_t               dir_q;
  logic [ADDR_W-1:0]  c_q;
  logic [ADDR_W-1:0]  s_q;
  logic               drop;
  logic [PIXEL_W-1:0] rdata_q;
  logic [PIXEL_W-1:0] stage     [NUM_INIT];
  logic [PIXEL_W-1:0] stage_eff [NUM_INIT];
  logic [PIXEL_W-1:0] win       [NUM_INIT];
  logic [ADDR_W-1:0]  tgt_addr;
  logic               accept_move;
  logic               last_pix;
  logic               wd_expire;
  logic               unused_stride_hi;

  assign unused_stride_hi = ^row_stride[11:ADDR_W];
  assign accept_move = !load_initial && (state == IDLE) && move_strobe && window_valid;
  assign last_pix    = (idx == last_index(init_q));

  win_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .center (c_q),
    .stride (s_q),
    .init   (init_q),
    .dir    (dir_q),
    .idx    (idx),
    .addr   (tgt_addr)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    mem_rd     = 1'b0;
    busy       = (state != IDLE);
    fetch_done = 1'b0;
    case (state)
      IDLE: begin
        if (accept_move) state_nxt = (dir_t'(direction) == DIR_NONE) ? COMMIT : REQ;
      end
      REQ: begin
        // While draining an aborted read no new request may be issued.
        mem_rd = !drop;
        if (mem_rvalid && !drop) state_nxt = CAPTURE;
        else if (wd_expire)      state_nxt = IDLE;
      end
      CAPTURE: state_nxt = last_pix ? COMMIT : REQ;
      COMMIT: begin
        fetch_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (load_initial) state_nxt = REQ;
  end

  assign mem_addr = mem_rd ? tgt_addr : '0;

  // The last pixel goes straight from rdata_q into the window so it is updated when fetch_done rises.
  always_comb begin
    for (int i = 0; i < NUM_INIT; i++)
      stage_eff[i] = (IDX_W'(i) == idx) ? rdata_q : stage[i];
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      c_q          <= '0;
      s_q          <= '0;
      init_q       <= 1'b0;
      dir_q        <= DIR_NONE;
      idx          <= '0;
      drop         <= 1'b0;
      rdata_q      <= '0;
      window_valid <= 1'b0;
      for (int i = 0; i < NUM_INIT; i++) begin
        stage[i] <= '0;
        win[i]   <= '0;
      end
    end else if (load_initial) begin
      c_q    <= center_addr;
      s_q    <= row_stride[ADDR_W-1:0];
      init_q <= 1'b1;
      dir_q  <= DIR_NONE;
      idx    <= '0;
      drop   <= (state == REQ) && !mem_rvalid;
      if (state != IDLE) window_valid <= 1'b0;
    end else begin
      if (accept_move) begin
        c_q    <= center_addr;
        s_q    <= row_stride[ADDR_W-1:0];
        init_q <= 1'b0;
        dir_q  <= dir_t'(direction);
        idx    <= '0;
      end
      if (state == REQ && mem_rvalid) begin
        if (drop) drop    <= 1'b0;
        else      rdata_q <= mem_rdata;
      end
      if (state == CAPTURE) begin
        stage[idx] <= rdata_q;
        idx        <= idx + 1'b1;
        if (last_pix) begin
          window_valid <= 1'b1;
          if (init_q) begin
            for (int i = 0; i < NUM_INIT; i++) win[i] <= stage_eff[i];
          end else begin
            case (dir_q)
              DIR_RIGHT: for (int r = 0; r < 3; r++) begin
                win[r*3]   <= win[r*3+1];
                win[r*3+1] <= win[r*3+2];
                win[r*3+2] <= stage_eff[r];
              end
              DIR_LEFT: for (int r = 0; r < 3; r++) begin
                win[r*3+2] <= win[r*3+1];
                win[r*3+1] <= win[r*3];
                win[r*3]   <= stage_eff[r];
              end
              DIR_DOWN: for (int c = 0; c < 3; c++) begin
                win[c]   <= win[3+c];
                win[3+c] <= win[6+c];
                win[6+c] <= stage_eff[c];
              end
              default: ;
            endcase
          end
        end
      end
      if (wd_expire) begin
        window_valid <= 1'b0;
        drop         <= 1'b0;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            error_q;

  assign wd_expire   = (state == REQ) && !mem_rvalid && !load_initial && (wd_cnt == '0);
  assign fetch_error = error_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)                                                   wd_cnt <= WD_W'(TIMEOUT_CYC - 1);
    else if (state == REQ && !mem_rvalid && !load_initial && !wd_expire) wd_cnt <= wd_cnt - 1'b1;
    else                                                            wd_cnt <= WD_W'(TIMEOUT_CYC - 1);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)          error_q <= 1'b0;
    else if (load_initial) error_q <= 1'b0;
    else if (wd_expire)    error_q <= 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
  assign wd_expire      = 1'b0;
  assign fetch_error    = 1'b0;
`endif

  always_comb begin
    window = '0;
    for (int i = 0; i < NUM_INIT; i++) window[i*PIXEL_W +: PIXEL_W] = win[i];
  end

endmodule

// File: tb/tb_window_fetch_unit.sv
// Self-checking bench for window_fetch_unit: directed cases plus random serpentine walks
// checked against a neighbourhood model of an SRAM array.
module tb_window_fetch_unit;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        load_initial, move_strobe;
  logic [1:0]  direction;
  logic [7:0]  center_addr;
  logic [11:0] row_stride;
  logic        mem_rd;
  logic [7:0]  mem_addr, mem_rdata;
  logic        mem_rvalid;
  logic [71:0] window;
  logic        window_valid, busy, fetch_done, fetch_error;

  window_fetch_unit #(.PIXEL_W(8), .ADDR_W(8), .TIMEOUT_CYC(255)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .load_initial (load_initial),
    .move_strobe  (move_strobe),
    .direction    (direction),
    .center_addr  (center_addr),
    .row_stride   (row_stride),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid),
    .window       (window),
    .window_valid (window_valid),
    .busy         (busy),
    .fetch_done   (fetch_done),
    .fetch_error  (fetch_error)
  );

  always #5 clk = ~clk;

  // SRAM model: rvalid arrives in the lat-th cycle of a request; a started read completes even if mem_rd drops.
  logic [7:0] mem_arr [256];
  int         lat;
  bit         hold;
  logic       m_busy;
  int         m_cnt;
  logic [7:0] m_addr;

  assign mem_rvalid = !hold && ((lat == 1) ? mem_rd : (m_busy && m_cnt == 1));
  assign mem_rdata  = (lat == 1) ? mem_arr[mem_addr] : mem_arr[m_addr];

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_addr <= 8'h00;
    end else if (lat > 1 && !hold) begin
      if (!m_busy && mem_rd) begin
        m_busy <= 1'b1;
        m_cnt  <= lat - 1;
        m_addr <= mem_addr;
      end else if (m_busy) begin
        if (m_cnt == 1) m_busy <= 1'b0;
        else            m_cnt  <= m_cnt - 1;
      end
    end
  end

  logic [7:0] rd_q [$];
  int         done_cnt;

  always @(posedge clk) begin
    if (n_reset !== 1'b1) done_cnt <= 0;
    else if (fetch_done)  done_cnt <= done_cnt + 1;
    if (mem_rd && mem_rvalid) rd_q.push_back(mem_addr);
  end

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] cur_c, cur_s;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] nb_addr(input logic [7:0] c, input logic [7:0] s, input int r, input int col);
    int a;
    a = int'(c) + (r - 1) * int'(s) + (col - 1);
    return a[7:0];
  endfunction

  function automatic logic [71:0] nb_window(input logic [7:0] c, input logic [7:0] s);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int col = 0; col < 3; col++)
        w[(r*3+col)*8 +: 8] = mem_arr[nb_addr(c, s, r, col)];
    return w;
  endfunction

  // Addresses a fetch must read, in issue order; n returns how many.
  function automatic logic [71:0] exp_reads(input bit init, input logic [1:0] d, input logic [7:0] c,
                                            input logic [7:0] s, output int n);
    logic [71:0] p;
    bit          take;
    p = '0;
    n = 0;
    for (int r = 0; r < 3; r++)
      for (int col = 0; col < 3; col++) begin
        take = init || (d == 2'b01 && col == 2) || (d == 2'b10 && col == 0) || (d == 2'b11 && r == 2);
        if (take) begin
          p[n*8 +: 8] = nb_addr(c, s, r, col);
          n++;
        end
      end
    return p;
  endfunction

  function automatic logic [71:0] got_reads(input int base);
    logic [71:0] p;
    p = '0;
    for (int i = 0; i < 9 && base + i < rd_q.size(); i++) p[i*8 +: 8] = rd_q[base + i];
    return p;
  endfunction

  task automatic wait_done(input bit noise, output int cyc);
    cyc = 1;
    while (fetch_done !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      move_strobe = noise && (cyc == 3);
      if (move_strobe) direction = 2'($urandom);
    end
    move_strobe = 1'b0;
    chk("done_seen", fetch_done, 1'b1);
  endtask

  task automatic do_fetch(input string tag, input bit init, input logic [1:0] d, input logic [7:0] c,
                          input bit noise);
    int          base, cyc, n, exp_cyc;
    logic [71:0] exp_p;
    base = rd_q.size();
    @(negedge clk);
    load_initial = init;
    move_strobe  = !init;
    direction    = d;
    center_addr  = c;
    row_stride   = {4'($urandom), cur_s};
    @(negedge clk);
    load_initial = 1'b0;
    move_strobe  = 1'b0;
    direction    = 2'($urandom);
    center_addr  = 8'($urandom);
    row_stride   = 12'($urandom);
    wait_done(noise, cyc);
    cur_c   = c;
    exp_p   = exp_reads(init, d, c, cur_s, n);
    exp_cyc = (n == 0) ? 1 : n * (lat + 1) + 1;
    chk({tag, "_cycles"}, cyc, exp_cyc);
    chk({tag, "_nreads"}, rd_q.size() - base, n);
    chk({tag, "_addrs"}, got_reads(base), exp_p);
    chk({tag, "_window"}, window, nb_window(cur_c, cur_s));
    chk({tag, "_valid"}, window_valid, 1'b1);
    @(negedge clk);
    chk({tag, "_pulse"}, {fetch_done, busy}, 2'b00);
  endtask

  initial begin
    int          n, cyc, base, d0, nexp;
    logic [1:0]  d;
    logic [7:0]  c;
    logic [71:0] exp_p;

    n_reset = 1'b0; load_initial = 1'b0; move_strobe = 1'b0;
    direction = 2'b00; center_addr = 8'h00; row_stride = 12'h000;
    lat = 1; hold = 1'b0;
    for (int i = 0; i < 256; i++) mem_arr[i] = 8'(i);
    repeat (3) @(negedge clk);
    chk("reset_outs", {window, window_valid, busy, fetch_done, mem_rd, mem_addr, fetch_error}, '0);
    n_reset = 1'b1;

    // A move before any window is loaded must be ignored.
    @(negedge clk);
    move_strobe = 1'b1; direction = 2'b01; center_addr = 8'h23; row_stride = 12'd16;
    @(negedge clk);
    move_strobe = 1'b0;
    chk("move_nowin_busy", busy, 1'b0);
    repeat (4) @(negedge clk);
    chk("move_nowin_quiet", {32'(done_cnt), 32'(rd_q.size())}, 64'h0);

    cur_s = 8'd16;
    do_fetch("init22", 1'b1, 2'b00, 8'h22, 1'b0);
    chk("init22_lit", window, 72'h33_32_31_23_22_21_13_12_11);
    do_fetch("right23", 1'b0, 2'b01, 8'h23, 1'b0);
    chk("right23_lit", window, 72'h34_33_32_24_23_22_14_13_12);
    do_fetch("down33", 1'b0, 2'b11, 8'h33, 1'b0);
    chk("down33_lit", window, 72'h44_43_42_34_33_32_24_23_22);
    do_fetch("left32", 1'b0, 2'b10, 8'h32, 1'b0);
    chk("left32_lit", window, 72'h43_42_41_33_32_31_23_22_21);
    do_fetch("dir_none", 1'b0, 2'b00, 8'h32, 1'b0);
    do_fetch("busy_move", 1'b0, 2'b01, 8'h33, 1'b1);

    // Abort a move during its second read; the stale response must be dropped.
    lat  = 3;
    base = rd_q.size();
    d0   = done_cnt;
    @(negedge clk);
    move_strobe = 1'b1; direction = 2'b01; center_addr = 8'h34; row_stride = {4'h0, cur_s};
    @(negedge clk);
    move_strobe = 1'b0;
    n = 0;
    while (!(rd_q.size() == base + 1 && mem_rd) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach", n < 200, 1'b1);
    load_initial = 1'b1; center_addr = 8'h55;
    base = rd_q.size();
    @(negedge clk);
    load_initial = 1'b0;
    chk("abort_valid_clr", {window_valid, busy}, 2'b01);
    wait_done(1'b0, cyc);
    cur_c = 8'h55;
    exp_p = exp_reads(1'b1, 2'b00, cur_c, cur_s, nexp);
    chk("abort_nreads", rd_q.size() - base, nexp);
    chk("abort_addrs", got_reads(base), exp_p);
    chk("abort_window", window, nb_window(cur_c, cur_s));
    @(negedge clk);
    chk("abort_one_done", done_cnt - d0, 1);

    lat = 1;
    do_fetch("wrap00", 1'b1, 2'b00, 8'h00, 1'b0);
    chk("wrap00_lit", window, 72'h11_10_0f_01_00_ff_f1_f0_ef);

`ifdef FETCH_TIMEOUT_EN
    hold = 1'b1;
    d0   = done_cnt;
    @(negedge clk);
    load_initial = 1'b1; center_addr = 8'h40; row_stride = {4'h0, cur_s};
    @(negedge clk);
    load_initial = 1'b0;
    n = 1;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", n, 256);
    chk("to_flags", {fetch_error, busy, window_valid}, 3'b100);
    chk("to_no_done", done_cnt - d0, 0);
    hold = 1'b0;
    @(negedge clk);
    load_initial = 1'b1;
    @(negedge clk);
    load_initial = 1'b0;
    chk("to_clear", fetch_error, 1'b0);
    wait_done(1'b0, cyc);
    chk("to_reload_window", window, nb_window(8'h40, cur_s));
    @(negedge clk);
`endif

    // Random serpentine walks over random image data, stride and memory latency.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 256; i++) mem_arr[i] = 8'($urandom);
      lat   = $urandom_range(1, 4);
      cur_s = 8'($urandom);
      do_fetch("rnd_init", 1'b1, 2'b00, 8'($urandom), 1'b0);
      for (int k = 0; k < 12; k++) begin
        d = 2'($urandom_range(0, 3));
        case (d)
          2'b01:   c = cur_c + 8'd1;
          2'b10:   c = cur_c - 8'd1;
          2'b11:   c = cur_c + cur_s;
          default: c = cur_c;
        endcase
        do_fetch("rnd_move", 1'b0, d, c, (d != 2'b00) && ($urandom_range(0, 3) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
